pokey_timer_bank: RTL
=====================

Name: pokey_timer_bank

Overview:
- Parametrised successor to the single 8-bit POKEY audio/timer divider.
- N independent W-bit down-counters share one base-clock tick enable (`enn`).
- Channels pair up under per-pair link control into 2W-bit counters.
- Sits between the register decode (`wr` strobes, data bus, STIMER restart) and the audio/IRQ logic, which consume per-channel active-low borrow pulses (`nBor`).

Parameters:
- W, 8, counter and reload register width per channel (>=2).
- N, 4, channel count; must be even (pairs 0/1, 2/3, ...).

Ports:
- clk  in  1  system clock; all state updates on falling edge.
- rst  in  1  asynchronous reset, active-high.
- enn  in  1  base-clock tick enable; counters advance only on edges where enn=1.
- d  in  W  write data for reload registers.
- wr  in  N  per-channel reload-register write strobe.
- ld  in  1  STIMER restart: reloads every counter from its reload register.
- link  in  N/2  link[k]=1 joins channels 2k (low) and 2k+1 (high) into one 2W-bit counter.
- nBor  out  N  per-channel borrow, active-low, one clk wide.

Behaviour:
- Reset (async, rst=1): counters=0, reload regs=0, nBor=all 1s, pipeline flags cleared.
- Reset mid-count abandons all counts immediately; no borrow is emitted on release.
- Reload register write: wr[i]=1 on any falling edge, independent of enn, latches d into reload[i].
- Write ordering: a same-edge load or reload uses the old reload value; the new value takes effect at the next load or reload.
- Load: ld=1 with enn=1 sets every counter to its reload value and forces nBor=1. No counting happens that edge. ld=1 with enn=0 is ignored.
- Unlinked channel i, enn=1, ld=0:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: cnt<=reload[i] and nBor[i] is driven 0 for the next clk cycle.
  - Period = reload+1 ticks; reload=0 gives a borrow every tick.
- Linked pair k, enn=1, ld=0, 2W-bit value V={cnt[2k+1],cnt[2k]}:
  - V!=0: V<=V-1, with the low half wrapping 0 -> 2^W-1 and borrowing from the high half.
  - V==0: V<={reload[2k+1],reload[2k]} and nBor[2k+1]=0 for one cycle.
  - nBor[2k] is held 1 while linked.
- Link change: takes effect on the next enn edge; counters are not disturbed and no spurious borrow is allowed.
  - Link set: the pair continues from the current concatenated value.
  - Link cleared: halves continue independently.
- nBor is registered and returns to 1 on the next falling edge unless a new borrow occurs.
- enn=0: counters hold; nBor returns to 1.
- Arithmetic: unsigned modulo 2^W (or 2^2W when linked); no saturation.

Optional Feature:
- Macro POKEY_TIMER_IRQ_EN.
- Enabled: adds ports irq_clr (in, N) and irq (out, N).
  - irq[i] is set on any cycle nBor[i] is 0 and stays set until irq_clr[i]=1.
  - Set wins over a same-edge clear.
  - irq resets to 0.
  - Linked low channels never set irq.
- Disabled: ports absent and no flag logic; all other behaviour identical.

Decomposition:
- Package pokey_timer_pkg:
  - default W and N constants.
  - function for linked-pair index mapping.
  - typedef for the reload register array.
- Sub-module pokey_timer_chan: one W-bit counter plus reload register, with borrow-in/borrow-out and zero-detect. The bank instantiates N copies and does link muxing, load distribution and the optional IRQ flags.

Test Plan:
- Reset then W=8, reload[0]=3, ld pulse, enn every clk -> nBor[0] low exactly every 4th cycle, counter sequence 3,2,1,0,3.
- reload[1]=0, enn every 3rd clk -> nBor[1] low one clk after each enn edge, never on non-enn edges.
- link[0]=1, reload[0]=0x02, reload[1]=0x01 (V=0x0102), ld -> first nBor[1] low after 259 ticks; nBor[0] stays 1 throughout.
- wr[2] with d=5 on the same edge as channel 2 reaches 0 (old reload 9) -> reload to 9, next period 10 ticks, following period 6 ticks.
- rst asserted mid-count with nBor low -> nBor goes all 1s and counters 0 asynchronously, without waiting for a clk edge.
- Compile with POKEY_TIMER_IRQ_EN: borrow on channel 3 -> irq[3]=1; irq_clr[3] on the same edge as the next borrow -> irq[3] stays 1; a later lone clear -> 0.

Source files
------------

// File: rtl/pokey_timer_pkg.sv
// pokey_timer_pkg: shared constants, types and helpers for the POKEY timer bank.
//   DefW / DefN   default counter width and channel count
//   reload_arr_t  reload register array at the default geometry
//   pair_lo/hi    channel indices that make up linked pair k
//   pair_of       pair index that a channel belongs to
package pokey_timer_pkg;

  localparam int unsigned DefW = 8;
  localparam int unsigned DefN = 4;

  typedef logic [DefW-1:0] reload_arr_t [DefN];

  function automatic int unsigned pair_lo(input int unsigned k);
    return 2 * k;
  endfunction

  function automatic int unsigned pair_hi(input int unsigned k);
    return 2 * k + 1;
  endfunction

  function automatic int unsigned pair_of(input int unsigned ch);
    return ch / 2;
  endfunction

endpackage

// File: rtl/pokey_timer_chan.sv
// pokey_timer_chan: one W-bit down-counter with its reload register.
//   clk, rst  falling-edge clock, async active-high reset
//   tick_i    counting edge (enn=1, ld=0)
//   load_i    restart edge (enn=1, ld=1): counter <= reload
//   wr_i, d_i reload register write, independent of tick
//   bin_i     borrow-in: this channel steps on a tick only when set
//   rld_i     on a stepping tick, reload instead of decrement
//   zero_o    counter is zero (borrow-out towards a linked high half)
module pokey_timer_chan
  import pokey_timer_pkg::*;
#(
  parameter int unsigned W = DefW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_i,
  input  logic         load_i,
  input  logic         wr_i,
  input  logic [W-1:0] d_i,
  input  logic         bin_i,
  input  logic         rld_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] reload_q, reload_d;

  // Reload/load read reload_q, so a same-edge write only lands next time.
  always_comb begin
    reload_d = wr_i ? d_i : reload_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      cnt_d = reload_q;
    end else if (tick_i && bin_i) begin
      // Decrement wraps 0 -> all-ones, which is the linked low-half behaviour.
      cnt_d = rld_i ? reload_q : cnt_q - W'(1);
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      reload_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pokey_timer_bank.sv
// pokey_timer_bank: N independent W-bit POKEY-style timers with per-pair linking.
//   clk      system clock, state updates on the falling edge
//   rst      async active-high reset
//   enn      base-clock tick enable
//   d, wr    reload data and per-channel reload write strobes
//   ld       STIMER restart (only honoured with enn=1)
//   link     link[k] chains channel 2k (low) into 2k+1 (high)
//   nBor     per-channel active-low registered borrow pulse
// Optional (POKEY_TIMER_IRQ_EN): irq_clr in / irq out, sticky per-channel
// borrow flags where a set beats a same-edge clear.
module pokey_timer_bank
  import pokey_timer_pkg::*;
#(
  parameter int unsigned W = DefW,
  parameter int unsigned N = DefN
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enn,
  input  logic [W-1:0]   d,
  input  logic [N-1:0]   wr,
  input  logic           ld,
  input  logic [N/2-1:0] link,
`ifdef POKEY_TIMER_IRQ_EN
  input  logic [N-1:0]   irq_clr,
  output logic [N-1:0]   irq,
`endif
  output logic [N-1:0]   nBor
);

  localparam int unsigned P = N / 2;

  logic         tick, load;
  logic [N-1:0] zero, bin, rld, bor;
  logic [N-1:0] nbor_d, nbor_q;

  assign tick = enn & ~ld;
  assign load = enn & ld;

  for (genvar i = 0; i < int'(N); i++) begin : g_chan
    pokey_timer_chan #(
      .W(W)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .tick_i (tick),
      .load_i (load),
      .wr_i   (wr[i]),
      .d_i    (d),
      .bin_i  (bin[i]),
      .rld_i  (rld[i]),
      .zero_o (zero[i])
    );
  end

  // Link muxing is purely combinational on the current counters, so a link
  // change just re-routes the next tick and never disturbs the counts.
  always_comb begin
    bin = '1;
    rld = zero;
    bor = '0;
    for (int unsigned k = 0; k < P; k++) begin
      if (link[k]) begin
        // High half steps only when the low half wraps; rld for the high half
        // stays zero[hi], which only matters when it is stepping.
        bin[pair_hi(k)] = zero[pair_lo(k)];
        rld[pair_lo(k)] = zero[pair_lo(k)] & zero[pair_hi(k)];
        bor[pair_hi(k)] = tick & zero[pair_lo(k)] & zero[pair_hi(k)];
      end else begin
        bor[pair_lo(k)] = tick & zero[pair_lo(k)];
        bor[pair_hi(k)] = tick & zero[pair_hi(k)];
      end
    end
    nbor_d = ~bor;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      nbor_q <= '1;
    end else begin
      nbor_q <= nbor_d;
    end
  end

  assign nBor = nbor_q;

`ifdef POKEY_TIMER_IRQ_EN
  logic [N-1:0] irq_q, irq_d;

  // Flag rises on the same edge that drives nBor low; linked low halves
  // never borrow, so they never set a flag.
  always_comb begin
    irq_d = (irq_q & ~irq_clr) | bor;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= '0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule
